// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU and the data memory.
// The LSU holds dm_req until a single-cycle dm_ack returns.
interface mem_stage_lsu_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_be,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_be,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX/MEM controls -> data-memory handshake.
// Optional LSU_ERR_STATUS_EN adds sticky err_addr/err_code outputs.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    mem_stage_lsu_if.master       dm,
    output logic [31:0]           load_data,
`ifdef LSU_ERR_STATUS_EN
    output logic [31:0]           err_addr,
    output logic [1:0]            err_code,
`endif
    output logic                  stall,
    output logic                  misalign,
    output logic                  bus_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
`ifdef LSU_ERR_STATUS_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic [1:0]  err_code_q, err_code_d;
`endif

    logic        valid;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rshift;
    logic [31:0] rfmt;
    logic [7:0]  cnt_inc;

    assign valid   = mem_read | mem_write;
    assign cnt_inc = cnt_q + 8'd1;
    assign rshift  = dm.dm_rdata >> {addr_q[1:0], 3'b000};

    // Alignment check and lane placement of the incoming request
    always_comb begin
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = wdata;
        unique case (mem_size)
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr[0];
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                aligned = (addr[1:0] == 2'b00);
            end
        endcase
    end

    // Extract the addressed lane from returned data and extend it
    always_comb begin
        unique case (size_q)
            2'b00:   rfmt = {{24{~uns_q & rshift[7]}}, rshift[7:0]};
            2'b01:   rfmt = {{16{~uns_q & rshift[15]}}, rshift[15:0]};
            default: rfmt = dm.dm_rdata;
        endcase
    end

    // Next-state and output computation for the IDLE/ACCESS/DONE sequence
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        stall      = 1'b0;
`ifdef LSU_ERR_STATUS_EN
        err_addr_d = err_addr_q;
        err_code_d = err_code_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (valid && aligned) begin
                    stall   = 1'b1;
                    state_d = S_ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = addr;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    size_d  = mem_size;
                    uns_d   = mem_unsigned;
                    cnt_d   = 8'd0;
                end else if (valid) begin
                    misalign_d = 1'b1;
                    load_d     = 32'd0;
`ifdef LSU_ERR_STATUS_EN
                    if (err_code_q == 2'b00) begin
                        err_addr_d = addr;
                        err_code_d = 2'b01;
                    end
`endif
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (dm.dm_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        load_d = rfmt;
                    end
                end else if (cnt_inc == TIMEOUT_CYCLES[7:0]) begin
                    req_d     = 1'b0;
                    cnt_d     = 8'd0;
                    bus_err_d = 1'b1;
                    load_d    = 32'd0;
                    state_d   = S_DONE;
`ifdef LSU_ERR_STATUS_EN
                    if (err_code_q == 2'b00) begin
                        err_addr_d = addr_q;
                        err_code_d = 2'b10;
                    end
`endif
                end
            end
            S_DONE: begin
                // Inputs here still belong to the finished instruction
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            cnt_q      <= 8'd0;
            load_q     <= 32'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef LSU_ERR_STATUS_EN
            err_addr_q <= 32'd0;
            err_code_q <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
`ifdef LSU_ERR_STATUS_EN
            err_addr_q <= err_addr_d;
            err_code_q <= err_code_d;
`endif
        end
    end

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = {addr_q[31:2], 2'b00};
    assign dm.dm_be    = be_q;
    assign dm.dm_wdata = wdata_q;
    assign load_data   = load_q;
    assign misalign    = misalign_q;
    assign bus_err     = bus_err_q;
`ifdef LSU_ERR_STATUS_EN
    assign err_addr    = err_addr_q;
    assign err_code    = err_code_q;
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns EX/MEM load/store controls into a handshaked request to data memory, and formats load data for MEM/WB.
- Stalls the pipeline while an access is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: number of ACCESS cycles without dm_ack before the access is abandoned (range 1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read  in  1  load in MEM stage.
- mem_write  in  1  store in MEM stage; has priority if both are set.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned  in  1  zero-extend loads (lbu/lhu).
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data, right-justified.
- dm_req  out  1  memory request, held until ack.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word address, {addr[31:2],2'b00}.
- dm_be  out  4  byte enables; bit i = byte lane i (little-endian).
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  single-cycle completion strobe.
- dm_rdata  in  32  read data, valid with dm_ack.
- load_data  out  32  formatted load result, to MEM/WB.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- misalign  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a timeout.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE, timeout counter 0.
  - dm_req, dm_we, dm_be, dm_addr, dm_wdata, load_data, misalign, bus_err all 0.
  - Reset mid-ACCESS drops dm_req at that edge; a late dm_ack is ignored.
- Valid request: mem_read|mem_write.
- Alignment rules:
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
- IDLE:
  - stall is combinational: 1 when the request is valid and aligned.
  - Valid and aligned: latch dm_we/dm_addr/dm_be/dm_wdata, size, sign and lane; go to ACCESS.
  - Valid and misaligned: no request; misalign=1 next cycle; load_data<=0; stay IDLE; stall stays 0.
- ACCESS:
  - dm_req=1, stall=1; counter increments each cycle.
  - dm_ack: for a load, load_data<=formatted dm_rdata; go to DONE; counter cleared.
  - Counter reaches TIMEOUT_CYCLES without ack: dm_req drops; bus_err=1 in DONE; load_data<=0; go to DONE.
- DONE:
  - Exactly one cycle; stall=0, dm_req=0.
  - Inputs are ignored because they still belong to the finished instruction.
  - Always returns to IDLE.
- Latency: ack in the first ACCESS cycle gives stall high for 2 cycles; load_data is valid in DONE and is captured by MEM/WB at the DONE edge.
- Store lanes:
  - Byte: dm_wdata={4{wdata[7:0]}}, dm_be=1<<addr[1:0].
  - Half: dm_wdata={2{wdata[15:0]}}, dm_be = addr[1] ? 1100 : 0011.
  - Word: dm_wdata=wdata, dm_be=1111.
- Load format:
  - Shift dm_rdata right by 8*lane, take 8 or 16 bits, then sign- or zero-extend per mem_unsigned.
  - Word loads pass through unchanged.
- Stores leave load_data unchanged.
- Neither read nor write in IDLE: no activity, outputs hold.

Optional Feature:
- Macro: LSU_ERR_STATUS_EN.
- Defined:
  - Adds output err_addr (32) and err_code (2): 01 misalign, 10 timeout.
  - Both load on the misalign/bus_err event.
  - Both are sticky until reset (reset value 0).
  - The first error wins; later errors are ignored.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- lw, addr 0x100, dm_ack in the first ACCESS cycle with dm_rdata 0xDEADBEEF -> dm_addr 0x100, dm_be 1111, stall high 2 cycles, load_data 0xDEADBEEF in DONE.
- lb, addr 0x203, dm_rdata 0x80123456 -> load_data 0xFFFFFF80; repeat as lbu -> 0x00000080.
- sh, addr 0x302, wdata 0x0000ABCD -> dm_we 1, dm_be 1100, dm_wdata 0xABCDABCD, load_data unchanged.
- lw, addr 0x101 -> dm_req never asserted, stall 0, misalign pulses one cycle, load_data 0; with LSU_ERR_STATUS_EN, err_addr 0x101 and err_code 01.
- lw with dm_ack held low, TIMEOUT_CYCLES=4 -> dm_req high 4 cycles, bus_err pulse, load_data 0, stall falls in DONE.
- rst_n low during the 2nd ACCESS cycle -> dm_req 0 after that edge, state IDLE; a dm_ack pulse after reset causes no load_data change.
